// File: rtl/regfile_host_port_pkg.sv
// Shared opcodes, FSM encoding and width defaults for the RegFile host-side sequencer.
package srcv_rf_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_W     = 5;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RDP = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WRITE    = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_CAPT  = 3'd3;
  localparam logic [2:0] ST_RSP      = 3'd4;
  localparam logic [2:0] ST_CLEAR    = 3'd5;

endpackage

// File: rtl/regfile_host_port_if.sv
// Host command and read-response channels of the RegFile sequencer.
interface regfile_host_port_if
  import srcv_rf_pkg::*;
#(
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int REGFILE_ADDR_W = RF_ADDR_W
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_op;
  logic [REGFILE_ADDR_W-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]     cmd_wdata;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_data_a;
  logic [DATA_WIDTH-1:0]     rsp_data_b;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data_a, rsp_data_b
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/regfile_host_port.sv
// Sequences host write / pair-read / clear commands onto the RegFile port.
// state       | meaning
// ST_IDLE     | waiting for a command, cmd_ready high
// ST_WRITE    | single write cycle on the RegFile port
// ST_RD_ISSUE | read of addr and addr+1 issued
// ST_RD_CAPT  | RegFile registered outputs captured into the response
// ST_RSP      | response held until rsp_ready
// ST_CLEAR    | one zero write per cycle across the whole depth
module regfile_host_port
  import srcv_rf_pkg::*;
#(
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int REGFILE_ADDR_W = RF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_host_port_if.slave        host,
  output logic                      busy,
  output logic                      err_op,
  output logic                      rf_en,
  output logic                      rf_rw,
  output logic [REGFILE_ADDR_W-1:0] rf_a_ra,
  output logic [REGFILE_ADDR_W-1:0] rf_a_rb,
  output logic [REGFILE_ADDR_W-1:0] rf_a_rd,
  output logic [DATA_WIDTH-1:0]     rf_rd,
  input  logic [DATA_WIDTH-1:0]     rf_ra,
  input  logic [DATA_WIDTH-1:0]     rf_rb
);

  localparam logic [REGFILE_ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [REGFILE_ADDR_W-1:0] ADDR_ONE  = REGFILE_ADDR_W'(1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       cmd_fire;

  assign host.cmd_ready = (state == ST_IDLE) && !rst;
  assign cmd_fire       = host.cmd_valid && host.cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (host.cmd_op)
            OP_WR:   state_nxt = ST_WRITE;
            OP_RDP:  state_nxt = ST_RD_ISSUE;
            OP_CLR:  state_nxt = ST_CLEAR;
            default: state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_WRITE:    state_nxt = ST_IDLE;
      ST_RD_ISSUE: state_nxt = ST_RD_CAPT;
      ST_RD_CAPT:  state_nxt = ST_RSP;
      ST_RSP:      if (host.rsp_ready) state_nxt = ST_IDLE;
      ST_CLEAR:    if (rf_a_rd == LAST_ADDR) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      err_op          <= 1'b0;
      rf_en           <= 1'b0;
      rf_rw           <= 1'b0;
      rf_a_ra         <= '0;
      rf_a_rb         <= '0;
      rf_a_rd         <= '0;
      rf_rd           <= '0;
      host.rsp_valid  <= 1'b0;
      host.rsp_data_a <= '0;
      host.rsp_data_b <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      rf_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (host.cmd_op)
              OP_WR: begin
                rf_en   <= 1'b1;
                rf_rw   <= 1'b0;
                rf_a_rd <= host.cmd_addr;
                rf_rd   <= host.cmd_wdata;
              end
              OP_RDP: begin
                rf_en   <= 1'b1;
                rf_rw   <= 1'b1;
                rf_a_ra <= host.cmd_addr;
                rf_a_rb <= host.cmd_addr + ADDR_ONE;
              end
              OP_CLR: begin
                rf_en   <= 1'b1;
                rf_rw   <= 1'b0;
                rf_a_rd <= '0;
                rf_rd   <= '0;
              end
              OP_RSV:  err_op <= 1'b1;
              default: ;
            endcase
          end
        end
        ST_RD_CAPT: begin
          host.rsp_data_a <= rf_ra;
          host.rsp_data_b <= rf_rb;
          host.rsp_valid  <= 1'b1;
        end
        ST_RSP: begin
          if (host.rsp_ready) host.rsp_valid <= 1'b0;
        end
        ST_CLEAR: begin
          // rf_a_rd doubles as the clear counter; the last write leaves it at depth-1
          if (rf_a_rd != LAST_ADDR) begin
            rf_en   <= 1'b1;
            rf_a_rd <= rf_a_rd + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_host_port.sv
// Randomized and directed bench for regfile_host_port with a behavioural RegFile responder.
module tb_regfile_host_port;
  import srcv_rf_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk;
  logic          rst;
  logic          busy, err_op, rf_en, rf_rw;
  logic [AW-1:0] rf_a_ra, rf_a_rb, rf_a_rd;
  logic [DW-1:0] rf_rd, rf_ra, rf_rb;

  regfile_host_port_if #(.DATA_WIDTH(DW), .REGFILE_ADDR_W(AW)) host_if ();

  regfile_host_port #(.DATA_WIDTH(DW), .REGFILE_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .host(host_if.slave), .busy(busy), .err_op(err_op),
    .rf_en(rf_en), .rf_rw(rf_rw), .rf_a_ra(rf_a_ra), .rf_a_rb(rf_a_rb),
    .rf_a_rd(rf_a_rd), .rf_rd(rf_rd), .rf_ra(rf_ra), .rf_rb(rf_rb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RegFile responder: synchronous write, registered pair read, not reset
  logic [DW-1:0] rf_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) rf_mem[i] = '0;
    rf_ra = '0;
    rf_rb = '0;
  end
  always @(posedge clk) begin
    if (rf_en) begin
      if (!rf_rw) rf_mem[rf_a_rd] <= rf_rd;
      else begin
        rf_ra <= rf_mem[rf_a_ra];
        rf_rb <= rf_mem[rf_a_rb];
      end
    end
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic          err_exp;
  int            tests_run;
  int            tests_failed;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int addr, input logic [DW-1:0] wd);
    int n;
    n = 0;
    host_if.cmd_valid = 1'b1;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = AW'(addr);
    host_if.cmd_wdata = wd;
    while (!host_if.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("cmd_ready_timeout", 64'd0, 64'd1);
    tick();
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [DW-1:0] data);
    issue(OP_WR, addr, data);
    check("wr_en", rf_en, 1);
    check("wr_rw", rf_rw, 0);
    check("wr_addr", rf_a_rd, addr);
    check("wr_data", rf_rd, data);
    check("wr_busy", busy, 1);
    check("wr_ready_low", host_if.cmd_ready, 0);
    ref_mem[addr] = data;
    tick();
    check("wr_en_pulse", rf_en, 0);
    check("wr_ready_back", host_if.cmd_ready, 1);
    check("wr_busy_low", busy, 0);
  endtask

  task automatic do_read(input int addr, input int hold);
    int b;
    b = (addr + 1) % DEPTH;
    issue(OP_RDP, addr, '0);
    check("rd_en", rf_en, 1);
    check("rd_rw", rf_rw, 1);
    check("rd_a_ra", rf_a_ra, addr);
    check("rd_a_rb", rf_a_rb, b);
    tick();
    check("rd_en_pulse", rf_en, 0);
    check("rsp_early", host_if.rsp_valid, 0);
    tick();
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", host_if.rsp_valid, 1);
      check("hold_a", host_if.rsp_data_a, ref_mem[addr]);
      check("hold_b", host_if.rsp_data_b, ref_mem[b]);
      check("hold_cmd_ready", host_if.cmd_ready, 0);
      tick();
    end
    check("rsp_valid", host_if.rsp_valid, 1);
    check("rsp_a", host_if.rsp_data_a, ref_mem[addr]);
    check("rsp_b", host_if.rsp_data_b, ref_mem[b]);
    check("rsp_busy", busy, 1);
    host_if.rsp_ready = 1'b1;
    tick();
    host_if.rsp_ready = 1'b0;
    check("rsp_drop", host_if.rsp_valid, 0);
    check("rsp_ready_back", host_if.cmd_ready, 1);
  endtask

  task automatic do_reserved();
    issue(OP_RSV, 0, '0);
    err_exp = 1'b1;
    check("rsv_err", err_op, 1);
    check("rsv_en", rf_en, 0);
    check("rsv_busy", busy, 0);
    check("rsv_rsp", host_if.rsp_valid, 0);
    check("rsv_ready", host_if.cmd_ready, 1);
  endtask

  // abort_at < DEPTH raises rst so that clear write abort_at never happens
  task automatic do_clear(input int abort_at);
    bit aborted;
    aborted = 1'b0;
    issue(OP_CLR, 0, '0);
    for (int i = 0; i < DEPTH && !aborted; i++) begin
      check("clr_en", rf_en, 1);
      check("clr_rw", rf_rw, 0);
      check("clr_addr", rf_a_rd, i);
      check("clr_data", rf_rd, 0);
      check("clr_busy", busy, 1);
      check("clr_ready", host_if.cmd_ready, 0);
      ref_mem[i] = '0;
      if (i == abort_at - 1) begin
        rst = 1'b1;
        tick();
        err_exp = 1'b0;
        check("rst_en", rf_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_op, 0);
        check("rst_ready_low", host_if.cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_ready_back", host_if.cmd_ready, 1);
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    if (!aborted) begin
      check("clr_done_en", rf_en, 0);
      check("clr_done_busy", busy, 0);
      check("clr_done_ready", host_if.cmd_ready, 1);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    err_exp = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'b00;
    host_if.cmd_addr  = '0;
    host_if.cmd_wdata = '0;
    host_if.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset_en", rf_en, 0);
    check("reset_busy", busy, 0);
    check("reset_err", err_op, 0);
    check("reset_rsp", host_if.rsp_valid, 0);
    check("reset_ready", host_if.cmd_ready, 0);
    check("reset_a_rd", rf_a_rd, 0);
    check("reset_rd", rf_rd, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", host_if.cmd_ready, 1);

    do_write(3, 32'hDEADBEEF);
    do_write(4, 32'h12345678);
    do_read(3, 0);
    check("plan1_a", ref_mem[3], 32'hDEADBEEF);

    do_write(31, 32'hA5A5A5A5);
    do_write(0, 32'h5A5A5A5A);
    do_read(31, 0);

    do_read(3, 10);

    for (int i = 0; i < DEPTH; i++) do_write(i, DW'(i + 1));
    do_clear(DEPTH);
    for (int i = 0; i < DEPTH; i += 2) do_read(i, 0);

    do_reserved();
    tick();
    check("rsv_sticky", err_op, 1);
    check("rsv_no_en", rf_en, 0);
    do_write(7, 32'h1);
    check("rsv_err_kept", err_op, 1);
    do_read(7, 1);

    for (int i = 0; i < DEPTH; i++) do_write(i, DW'(i + 1));
    do_clear(10);
    for (int i = 0; i < DEPTH; i += 2) do_read(i, 0);

    for (int k = 0; k < 80; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3) do_write($urandom_range(0, DEPTH - 1), $urandom);
      else if (sel <= 7) do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, 3));
      else if (sel == 8) do_reserved();
      else repeat ($urandom_range(1, 3)) tick();
      check("rand_err", err_op, err_exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
